ov7670_cfg_seq: RTL
===================

OV7670_CFG_SEQ -- requirements
Module: ov7670_cfg_seq

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, i_clk frequency in Hz for delay timing.
REQ-002 SHALL have parameter SLAVE_ADDR, default 7'h21, 7-bit camera device address driven on o_slave_addr.
REQ-003 SHALL have parameter MAX_RETRY, default 3, NACKed-write reissues before error.
REQ-004 SHALL have parameter ACCEPT_TIMEOUT, default 1024, cycles allowed for i_busy to rise after a request.
REQ-005 SHALL have ports, clock and reset first:
i_clk  in  1  clock
i_rstn  in  1  reset, asynchronous, active-low
i_start  in  1  pulse; begins the configuration sequence
o_wr / o_rd  out  1  write / read request to I2C master
o_slave_addr  out  7  SLAVE_ADDR
o_reg_addr  out  8  register address
o_wdata  out  8  write data
i_rdata  in  8  read data from master
i_rdata_valid  in  1  read data valid
i_busy  in  1  master transaction in progress
i_nack_slave / i_nack_addr / i_nack_data  in  1  master NACK flags
o_busy  out  1  sequence running
o_done  out  1  sequence completed without error; sticky
o_error  out  1  sequence aborted; sticky
o_index  out  8  current ROM entry index

Function
REQ-006 SHALL fetch 16-bit entries {reg[15:8], data[7:0]} from ROM index 0 upward, one-cycle read latency.
REQ-007 SHALL treat 16'hFFFF as end-of-table -> DONE; 8'hFE in reg field as delay of data milliseconds, no bus transfer.
REQ-008 SHALL use states IDLE, FETCH, ISSUE, WAIT_BUSY, WAIT_DONE, CHECK, DELAY, DONE, ERROR.
REQ-009 IDLE: on i_start -> FETCH, index=0, o_busy=1, o_done=o_error=0; i_start ignored in all other states except DONE/ERROR (same as IDLE).
REQ-010 ISSUE: drive o_wr=1 with reg/data; hold o_wr until i_busy observed high (WAIT_BUSY), then deassert.
REQ-011 o_reg_addr, o_wdata SHALL stay stable from ISSUE until i_busy falls.
REQ-012 WAIT_BUSY: i_busy not high within ACCEPT_TIMEOUT cycles -> ERROR.
REQ-013 WAIT_DONE: on i_busy falling -> CHECK next cycle; CHECK samples the three NACK flags.
REQ-014 CHECK: any NACK -> retry counter+1, reissue same entry; counter exceeds MAX_RETRY -> ERROR; no NACK -> counter=0, index+1, FETCH.
REQ-015 DELAY: count data x (CLK_FREQ/1000) cycles; data=0 -> zero-length, advance next cycle.
REQ-016 index 8'hFF reached without end marker -> DONE after that entry (no wrap).
REQ-017 DONE/ERROR: o_busy=0, o_wr=o_rd=0; new i_start restarts from index 0.

Reset
REQ-018 Reset SHALL force IDLE, all outputs 0 except o_slave_addr=SLAVE_ADDR, retry and delay counters 0.
REQ-019 Reset mid-transaction SHALL deassert o_wr immediately; no further requests until next i_start.

Configuration
REQ-020 With OV7670_CFG_READBACK_EN defined: after each successful write (except reg 8'h12 data bit7 soft-reset), SHALL issue o_rd with same address (states RD_ISSUE, RD_WAIT), compare i_rdata on i_rdata_valid; mismatch counts as a NACK retry.
REQ-021 Without OV7670_CFG_READBACK_EN: o_rd tied 0, i_rdata/i_rdata_valid unused, no readback states.

Structure
REQ-022 Shared package ov7670_pkg SHALL hold state encoding, END_MARKER 16'hFFFF, DELAY_REG 8'hFE, default SLAVE_ADDR.
REQ-023 Table SHALL be sub-module ov7670_cfg_rom (8-bit addr in, registered 16-bit entry out).

Verification
REQ-024 Table {12 80, FE 0A, 12 04, FFFF}, master model ACKs -> write 12/80, ~10 ms idle, write 12/04, o_done=1, o_index=3.
REQ-025 Model NACKs data byte twice on entry 0, MAX_RETRY=3 -> three writes of entry 0, then o_done=1, o_error=0.
REQ-026 Model always NACKs slave address -> exactly 4 attempts, o_error=1, o_busy=0, o_wr=0.
REQ-027 Model never raises i_busy -> o_error=1 after 1024 cycles in WAIT_BUSY.
REQ-028 i_rstn low during WAIT_DONE -> all outputs reset next edge; later i_start runs from index 0.
REQ-029 READBACK_EN, model returns 8'h00 for written 8'h04 -> retried, then o_error=1 after MAX_RETRY.

Source files
------------

// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared constants and state encoding for the OV7670 configuration sequencer
// Readback states exist only when OV7670_CFG_READBACK_EN is defined.
package ov7670_pkg;

  localparam logic [15:0] END_MARKER         = 16'hFFFF;
  localparam logic [7:0]  DELAY_REG          = 8'hFE;
  localparam logic [6:0]  DEFAULT_SLAVE_ADDR = 7'h21;
  localparam logic [7:0]  COM7_REG           = 8'h12;
  localparam logic [7:0]  LAST_INDEX         = 8'hFF;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    CHECK,
    DELAY,
    DONE,
`ifdef OV7670_CFG_READBACK_EN
    RD_ISSUE,
    RD_WAIT,
`endif
    ERROR
  } state_e;

  // COM7 bit7 resets the sensor, so that register cannot be read back meaningfully
  function automatic logic is_soft_reset(input logic [7:0] reg_addr, input logic [7:0] data);
    return (reg_addr == COM7_REG) && data[7];
  endfunction

endpackage

// File: rtl/ov7670_cfg_rom.sv
// rtl/ov7670_cfg_rom.sv - camera register table, one-cycle registered read
// Entries are {reg, data}; FE xx is a delay of xx ms, FFFF terminates the table.
module ov7670_cfg_rom
  import ov7670_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [7:0]  i_addr,
  output logic [15:0] o_entry
);

  logic [15:0] entry_d;
  logic [15:0] entry_q;

  always_comb begin
    entry_d = END_MARKER;
    case (i_addr)
      8'd0:    entry_d = 16'h1280;
      8'd1:    entry_d = 16'hFE0A;
      8'd2:    entry_d = 16'h1204;
      default: entry_d = END_MARKER;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) entry_q <= 16'h0000;
    else         entry_q <= entry_d;
  end

  assign o_entry = entry_q;

endmodule

// File: rtl/ov7670_cfg_seq.sv
// rtl/ov7670_cfg_seq.sv - walks the register table and drives an I2C master with retries and delays
// Optional write readback/compare is enabled with OV7670_CFG_READBACK_EN.
module ov7670_cfg_seq
  import ov7670_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter logic [6:0]  SLAVE_ADDR     = DEFAULT_SLAVE_ADDR,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned ACCEPT_TIMEOUT = 1024
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_start,
  output logic       o_wr,
  output logic       o_rd,
  output logic [6:0] o_slave_addr,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_wdata,
  input  logic [7:0] i_rdata,
  input  logic       i_rdata_valid,
  input  logic       i_busy,
  input  logic       i_nack_slave,
  input  logic       i_nack_addr,
  input  logic       i_nack_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [7:0] o_index
);

  localparam int unsigned MS_CYCLES = (CLK_FREQ >= 1000) ? CLK_FREQ / 1000 : 1;
  localparam logic [31:0] MS_LAST   = 32'(MS_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(ACCEPT_TIMEOUT - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  ms_left_q, ms_left_d;
  logic [31:0] tick_q, tick_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic [15:0] rom_entry;
  logic        check_fail;
  logic        last_entry;

  // ROM is addressed with the next index so the entry is ready during FETCH
  ov7670_cfg_rom u_rom (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_addr  (index_d),
    .o_entry (rom_entry)
  );

  assign last_entry = (index_q == LAST_INDEX);

`ifdef OV7670_CFG_READBACK_EN
  logic rd_phase_q, rd_phase_d;
  logic rd_bad_q, rd_bad_d;
  assign check_fail = i_nack_slave | i_nack_addr | i_nack_data | (rd_phase_q & rd_bad_q);
`else
  logic unused_rd;
  assign unused_rd  = ^{i_rdata, i_rdata_valid};
  assign check_fail = i_nack_slave | i_nack_addr | i_nack_data;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      index_q    <= 8'h00;
      retry_q    <= 8'h00;
      reg_q      <= 8'h00;
      data_q     <= 8'h00;
      ms_left_q  <= 8'h00;
      tick_q     <= 32'h0;
      to_cnt_q   <= 32'h0;
`ifdef OV7670_CFG_READBACK_EN
      rd_phase_q <= 1'b0;
      rd_bad_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      retry_q    <= retry_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
      ms_left_q  <= ms_left_d;
      tick_q     <= tick_d;
      to_cnt_q   <= to_cnt_d;
`ifdef OV7670_CFG_READBACK_EN
      rd_phase_q <= rd_phase_d;
      rd_bad_q   <= rd_bad_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    retry_d    = retry_q;
    reg_d      = reg_q;
    data_d     = data_q;
    ms_left_d  = ms_left_q;
    tick_d     = tick_q;
    to_cnt_d   = to_cnt_q;
`ifdef OV7670_CFG_READBACK_EN
    rd_phase_d = rd_phase_q;
    rd_bad_d   = rd_bad_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (i_start) begin
          state_d = FETCH;
          index_d = 8'h00;
          retry_d = 8'h00;
        end
      end
      FETCH: begin
        if (rom_entry == END_MARKER) begin
          state_d = DONE;
        end else if (rom_entry[15:8] == DELAY_REG) begin
          state_d   = DELAY;
          ms_left_d = rom_entry[7:0];
          tick_d    = 32'h0;
        end else begin
          state_d = ISSUE;
          reg_d   = rom_entry[15:8];
          data_d  = rom_entry[7:0];
        end
      end
      ISSUE: begin
        state_d  = WAIT_BUSY;
        to_cnt_d = 32'h0;
`ifdef OV7670_CFG_READBACK_EN
        rd_phase_d = 1'b0;
`endif
      end
      WAIT_BUSY: begin
        if (i_busy)                   state_d = WAIT_DONE;
        else if (to_cnt_q == TO_LAST) state_d = ERROR;
        else                          to_cnt_d = to_cnt_q + 32'd1;
      end
      WAIT_DONE: begin
        if (!i_busy) state_d = CHECK;
      end
      CHECK: begin
        if (check_fail) begin
          if (retry_q == RETRY_MAX) begin
            state_d = ERROR;
          end else begin
            retry_d = retry_q + 8'd1;
            state_d = ISSUE;
          end
        end
`ifdef OV7670_CFG_READBACK_EN
        else if (!rd_phase_q && !is_soft_reset(reg_q, data_q)) begin
          state_d    = RD_ISSUE;
          rd_phase_d = 1'b1;
          rd_bad_d   = 1'b1;
          to_cnt_d   = 32'h0;
        end
`endif
        else begin
          retry_d = 8'h00;
          if (last_entry) state_d = DONE;
          else begin
            index_d = index_q + 8'd1;
            state_d = FETCH;
          end
        end
      end
      DELAY: begin
        if (ms_left_q == 8'h00) begin
          retry_d = 8'h00;
          if (last_entry) state_d = DONE;
          else begin
            index_d = index_q + 8'd1;
            state_d = FETCH;
          end
        end else if (tick_q == MS_LAST) begin
          tick_d    = 32'h0;
          ms_left_d = ms_left_q - 8'd1;
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
`ifdef OV7670_CFG_READBACK_EN
      RD_ISSUE: begin
        if (i_busy)                   state_d = RD_WAIT;
        else if (to_cnt_q == TO_LAST) state_d = ERROR;
        else                          to_cnt_d = to_cnt_q + 32'd1;
      end
      RD_WAIT: begin
        if (i_rdata_valid) rd_bad_d = (i_rdata != data_q);
        if (!i_busy)       state_d  = CHECK;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_wr    = 1'b0;
    o_rd    = 1'b0;
    o_busy  = 1'b1;
    o_done  = 1'b0;
    o_error = 1'b0;
    case (state_q)
      IDLE:             o_busy = 1'b0;
      ISSUE, WAIT_BUSY: o_wr   = 1'b1;
`ifdef OV7670_CFG_READBACK_EN
      RD_ISSUE:         o_rd   = 1'b1;
`endif
      DONE: begin
        o_busy = 1'b0;
        o_done = 1'b1;
      end
      ERROR: begin
        o_busy  = 1'b0;
        o_error = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_slave_addr = SLAVE_ADDR;
  assign o_reg_addr   = reg_q;
  assign o_wdata      = data_q;
  assign o_index      = index_q;

endmodule
